jam_perm_search: RTL

Parametrised exhaustive job-assignment engine: for N workers and N jobs it walks every permutation in lexicographic order, fetching each worker/job cost through an external cost-lookup port. For each permutation it sums the N costs, then reports the best total, the number of permutations reaching it, and the first permutation that reached it. It succeeds the fixed 8×8 minimum-cost job-assignment block and adds the following:
- configurable N and cost width;
- a START/BUSY handshake that allows re-runs;
- min/max search mode;
- the winning assignment as an output.

---
 rtl/jam_perm_search.sv | 139 +++++++++++++
 1 files changed

// File: rtl/jam_perm_search.sv
// rtl/jam_perm_search.sv - exhaustive lexicographic permutation search for min/max-cost job assignment
// Walks all N! worker->job assignments, summing looked-up costs and tracking the best total.
module jam_perm_search #(
  parameter int N  = 8,
  parameter int CW = 7,
  localparam int IW = (N > 2) ? $clog2(N) : 1,
  localparam int SW = CW + IW
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            MODE,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            BUSY,
  output logic [SW-1:0]   BestCost,
  output logic [15:0]     MatchCount,
  output logic [N*IW-1:0] BestPerm,
  output logic            Valid
);

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state, state_nx;
  logic [IW-1:0]   perm    [N];
  logic [IW-1:0]   perm_nx [N];
  logic [IW-1:0]   tmp     [N];
  logic [IW-1:0]   piv, succ;
  logic            last;
  logic [SW-1:0]   sum;
  logic            first, mode_q, better;
  logic [N*IW-1:0] perm_flat;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (START) state_nx = EVAL;
      EVAL:       if (W == LAST) state_nx = UPDATE;
      UPDATE:     state_nx = last ? DONE : EVAL;
      default:    state_nx = IDLE;
    endcase
  end

  // Successor: the suffix after the pivot is descending, so the rightmost
  // entry greater than the pivot is also the smallest such entry.
  always_comb begin
    piv  = '0;
    last = 1'b1;
    for (int i = 0; i < N - 1; i++)
      if (perm[i] < perm[i+1]) begin
        piv  = IW'(i);
        last = 1'b0;
      end
    succ = piv;
    for (int k = 0; k < N; k++)
      if (IW'(k) > piv && perm[k] > perm[piv]) succ = IW'(k);
    tmp       = perm;
    tmp[piv]  = perm[succ];
    tmp[succ] = perm[piv];
    perm_nx   = tmp;
    for (int m = 0; m < N; m++)
      if (IW'(m) > piv) perm_nx[m] = tmp[IW'(N - m + int'(piv))];
  end

  always_comb begin
    perm_flat = '0;
    for (int w = 0; w < N; w++) perm_flat[w*IW +: IW] = perm[w];
  end

  assign better = mode_q ? (sum > BestCost) : (sum < BestCost);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int w = 0; w < N; w++) perm[w] <= IW'(w);
      sum        <= '0;
      W          <= '0;
      J          <= '0;
      first      <= 1'b0;
      mode_q     <= 1'b0;
      BestCost   <= '0;
      MatchCount <= '0;
      BestPerm   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (START) begin
            for (int w = 0; w < N; w++) perm[w] <= IW'(w);
            sum    <= '0;
            W      <= '0;
            J      <= '0;
            first  <= 1'b1;
            mode_q <= MODE;
          end
        end
        EVAL: begin
          sum <= sum + SW'(Cost);
          if (W == LAST) begin
            W <= '0;
            J <= perm[0];
          end else begin
            W <= W + ONE;
            J <= perm[W + ONE];
          end
        end
        UPDATE: begin
          // first flag, not a zero compare, seeds the result so a zero sum is legal
          if (first || better) begin
            BestCost   <= sum;
            MatchCount <= 16'd1;
            BestPerm   <= perm_flat;
          end else if (sum == BestCost && MatchCount != 16'hFFFF) begin
            MatchCount <= MatchCount + 16'd1;
          end
          first <= 1'b0;
          if (last) begin
            J <= '0;
          end else begin
            perm <= perm_nx;
            sum  <= '0;
            J    <= perm_nx[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state == EVAL) || (state == UPDATE);
  assign Valid = (state == DONE);

endmodule
